// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_ctrl                                              |
// | Description : Data-memory access sequencer: load latency, sub-word extract |
// |               and extend, read-modify-write stores, misalignment errors.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_access_ctrl #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int              c_CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(MEM_LAT - 1);
   localparam logic [1:0]      c_SZ_WORD  = 2'b00;
   localparam logic [1:0]      c_SZ_HALF  = 2'b01;
   localparam logic [1:0]      c_SZ_BYTE  = 2'b10;
   localparam logic [1:0]      c_SZ_ILL   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_MERGE = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t          r_state;
   logic [c_CW-1:0] r_cnt;
   logic            r_write;
   logic [1:0]      r_size;
   logic            r_signed;
   logic [1:0]      r_addr_lo;
   logic [15:0]     r_wdata;
   logic [31:0]     r_word;

   logic            r_ready;
   logic            r_resp_valid;
   logic [31:0]     r_resp_rdata;
   logic            r_resp_err;
   logic [31:0]     r_mem_addr;
   logic            r_mem_wr;
   logic [31:0]     r_mem_wdata;

   logic            w_req_err;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [31:0]     w_load_ext;
   logic [31:0]     w_merged;

   assign req_ready  = r_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign mem_addr   = r_mem_addr;
   assign mem_wr     = r_mem_wr;
   assign mem_wdata  = r_mem_wdata;

   assign w_req_err = (req_size == c_SZ_ILL)
                    | ((req_size == c_SZ_HALF) & req_addr[0])
                    | ((req_size == c_SZ_WORD) & (req_addr[1:0] != 2'b00));

   // Lane selection and extension of the word arriving on the last READ edge.
   always_comb begin
      w_byte     = 8'h00;
      w_half     = 16'h0000;
      w_load_ext = mem_rdata;
      case (r_addr_lo)
         2'd0:    w_byte = mem_rdata[7:0];
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (r_size)
         c_SZ_HALF: w_load_ext = {{16{r_signed & w_half[15]}}, w_half};
         c_SZ_BYTE: w_load_ext = {{24{r_signed & w_byte[7]}}, w_byte};
         default:   w_load_ext = mem_rdata;
      endcase
   end

   // Replace only the addressed lane of the captured word.
   always_comb begin
      w_merged = r_word;
      if (r_size == c_SZ_HALF) begin
         if (r_addr_lo[1]) w_merged[31:16] = r_wdata;
         else              w_merged[15:0]  = r_wdata;
      end else begin
         case (r_addr_lo)
            2'd0:    w_merged[7:0]   = r_wdata[7:0];
            2'd1:    w_merged[15:8]  = r_wdata[7:0];
            2'd2:    w_merged[23:16] = r_wdata[7:0];
            default: w_merged[31:24] = r_wdata[7:0];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_write      <= 1'b0;
         r_size       <= 2'b00;
         r_signed     <= 1'b0;
         r_addr_lo    <= 2'b00;
         r_wdata      <= 16'h0000;
         r_word       <= 32'h0;
         r_ready      <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_resp_err   <= 1'b0;
         r_mem_addr   <= 32'h0;
         r_mem_wr     <= 1'b0;
         r_mem_wdata  <= 32'h0;
      end else begin
         r_mem_wr     <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= 32'h0;
         case (r_state)
            S_IDLE: begin
               // Ready rises one cycle after reset, so acceptance is gated on it.
               if (r_ready && req_valid) begin
                  r_ready    <= 1'b0;
                  r_write    <= req_write;
                  r_size     <= req_size;
                  r_signed   <= req_signed;
                  r_addr_lo  <= req_addr[1:0];
                  r_wdata    <= req_wdata[15:0];
                  r_mem_addr <= {req_addr[31:2], 2'b00};
                  if (w_req_err) begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                  end else if (req_write && (req_size == c_SZ_WORD)) begin
                     r_state     <= S_WRITE;
                     r_mem_wr    <= 1'b1;
                     r_mem_wdata <= req_wdata;
                  end else begin
                     r_state <= S_READ;
                     r_cnt   <= c_CNT_INIT;
                  end
               end else begin
                  r_ready <= 1'b1;
               end
            end
            S_READ: begin
               if (r_cnt == '0) begin
                  if (r_write) begin
                     r_word  <= mem_rdata;
                     r_state <= S_MERGE;
                  end else begin
                     r_resp_rdata <= w_load_ext;
                     r_resp_valid <= 1'b1;
                     r_state      <= S_RESP;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_MERGE: begin
               r_mem_wdata <= w_merged;
               r_mem_wr    <= 1'b1;
               r_state     <= S_WRITE;
            end
            S_WRITE: begin
               r_resp_valid <= 1'b1;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// Testbench for mem_access_ctrl: directed cases plus random accesses scored
// against a shift/mask memory model.
module tb_mem_access_ctrl;

   localparam int MEM_LAT = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem     [16];
   logic [31:0] ref_mem [16];
   int          n_checks = 0;
   int          n_err    = 0;

   assign mem_rdata = mem[mem_addr[5:2]];

   always #5 clk = ~clk;

   mem_access_ctrl #(.MEM_LAT(MEM_LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_wr     (mem_wr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_word(input int idx, input logic [31:0] val);
      mem[idx]     = val;
      ref_mem[idx] = val;
   endtask

   task automatic do_access(input logic wr, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd);
      logic [3:0]  idx;
      logic        err;
      logic        exp_wr;
      int          lat;
      int          sh;
      logic [31:0] word, mask, val, nw;
      int          resp_cyc = 0, n_wr = 0, wr_cyc = 0, n = 0;
      logic [31:0] got_wd = 0, got_wa = 0, got_rd = 0;
      logic        got_err = 0;

      // Reference model: plain shift/mask arithmetic on the addressed word.
      idx  = a[5:2];
      word = ref_mem[idx];
      err  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b00 && a[1:0] != 2'b00);
      sh   = (sz == 2'b01) ? (a[1] ? 16 : 0) : 8 * int'(a[1:0]);
      mask = (sz == 2'b00) ? 32'hFFFF_FFFF : (sz == 2'b01) ? 32'h0000_FFFF : 32'h0000_00FF;
      val  = (word >> sh) & mask;
      if (sg && sz != 2'b00 && ((val & ~(mask >> 1)) != 0)) val = val | ~mask;
      nw   = (sz == 2'b00) ? wd : ((word & ~(mask << sh)) | ((wd & mask) << sh));
      exp_wr = !err && wr;
      if (err)                    lat = 1;
      else if (!wr)               lat = MEM_LAT + 1;
      else if (sz == 2'b00)       lat = 2;
      else                        lat = MEM_LAT + 3;

      @(negedge clk);
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", {31'b0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_write  = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      for (int c = 1; c <= 20 && resp_cyc == 0; c++) begin
         if (mem_wr === 1'b1) begin
            n_wr++;
            wr_cyc = c;
            got_wd = mem_wdata;
            got_wa = mem_addr;
            mem[mem_addr[5:2]] = mem_wdata;
         end
         if (resp_valid === 1'b1) begin
            resp_cyc = c;
            got_rd   = resp_rdata;
            got_err  = resp_err;
         end else begin
            check("busy_ready", {31'b0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
         end
      end
      check("resp_cycle", 32'(resp_cyc), 32'(lat));
      check("resp_err", {31'b0, got_err}, {31'b0, err});
      if (err || !wr) check("resp_rdata", got_rd, err ? 32'h0 : val);
      check("wr_count", 32'(n_wr), exp_wr ? 32'd1 : 32'd0);
      if (exp_wr) begin
         check("wr_cycle", 32'(wr_cyc), 32'(lat - 1));
         check("wr_data", got_wd, nw);
         check("wr_addr", got_wa, {a[31:2], 2'b00});
         ref_mem[idx] = nw;
      end
      @(posedge clk);
      #1;
      check("ready_after", {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      logic [1:0]  rsz;
      logic [31:0] ra;
      for (int i = 0; i < 16; i++) set_word(i, $urandom);

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'b0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_err", {31'b0, resp_err}, 32'd0);
      check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      check("ready_at_fall", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("ready_after_rst", {31'b0, req_ready}, 32'd1);

      // Directed cases
      set_word(4, 32'hDEADBEEF);
      do_access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
      check("lw_value", ref_mem[4], 32'hDEADBEEF);
      set_word(4, 32'h80112233);
      do_access(1'b0, 2'b10, 1'b1, 32'h13, 32'h0);
      do_access(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
      set_word(4, 32'h11223344);
      do_access(1'b1, 2'b10, 1'b0, 32'h11, 32'h000000AB);
      check("sb_mem", mem[4], 32'h1122AB44);
      set_word(4, 32'h12345678);
      do_access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
      do_access(1'b1, 2'b00, 1'b0, 32'h06, 32'h55AA55AA);
      do_access(1'b1, 2'b01, 1'b0, 32'h21, 32'h1234);
      do_access(1'b0, 2'b11, 1'b1, 32'h20, 32'h0);
      do_access(1'b1, 2'b00, 1'b0, 32'h2C, 32'hA5A5F00D);
      do_access(1'b0, 2'b01, 1'b1, 32'h2E, 32'h0);

      // Reset during the READ of an SH aborts it
      set_word(5, 32'hCAFEF00D);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size  = 2'b01;
      req_addr  = 32'h16;
      req_wdata = 32'h0000BEEF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      reset     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("abort_mem_wr", {31'b0, mem_wr}, 32'd0);
         check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
         check("abort_ready", {31'b0, req_ready}, 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("abort_ready_after", {31'b0, req_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         check("post_abort_mem_wr", {31'b0, mem_wr}, 32'd0);
         check("post_abort_resp", {31'b0, resp_valid}, 32'd0);
         @(posedge clk);
         #1;
      end
      check("abort_mem_kept", mem[5], 32'hCAFEF00D);

      // Random accesses
      for (int i = 0; i < 60; i++) begin
         rsz = 2'($urandom);
         ra  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (rsz == 2'b00) ra[1:0] = 2'b00;
            if (rsz == 2'b01) ra[0]   = 1'b0;
         end
         do_access(1'($urandom), rsz, 1'($urandom), ra, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
